// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout and arbiter state encoding.
package noc_pkg;

  localparam int FLIT_W   = 20;
  localparam int DEST_LSB = 0;
  localparam int DEST_W   = 4;
  localparam int PAY_LSB  = 4;
  localparam int PAY_W    = 16;

  typedef struct packed {
    logic [PAY_W-1:0]  pay;
    logic [DEST_W-1:0] dest;
  } flit_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cluster_uplink_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request after ptr, wrapping modulo NREQ.
// Also used by the intra-cluster router arbiters.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            found
);

  logic [IW-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // ptr itself is visited last, so the most recent owner has lowest priority
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cluster_uplink_arbiter.sv
// Packet-locked round-robin arbiter for a cluster uplink; 1-cycle grant, then combinational pass-through, 1 idle cycle per tail.
// Backpressure: out_ready goes straight to the granted node's req_ready. UPLINK_ARB_STATS_EN adds per-node packet counters.
module cluster_uplink_arbiter
  import noc_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int FLIT_W = noc_pkg::FLIT_W
`ifdef UPLINK_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*FLIT_W-1:0]    req_flit,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic                      out_valid,
  output logic [FLIT_W-1:0]         out_flit,
  output logic                      out_last,
  output logic [$clog2(NREQ)-1:0]   out_src,
  input  logic                      out_ready,
  output logic                      busy
`ifdef UPLINK_ARB_STATS_EN
  , output logic [NREQ*CNT_W-1:0]   stat_pkts
`endif
);

  localparam int IW = $clog2(NREQ);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] g, g_nxt;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          tail_xfer;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign tail_xfer = (state == LOCKED) && req_valid[g] && req_last[g] && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= IW'(NREQ - 1);
      g     <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      g     <= g_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    g_nxt     = g;
    req_ready = '0;
    out_valid = 1'b0;
    out_flit  = '0;
    out_last  = 1'b0;
    out_src   = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        // the grant cycle moves no data; the flit appears once LOCKED
        if (pick_found) begin
          g_nxt     = pick_idx;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        busy         = 1'b1;
        out_valid    = req_valid[g];
        out_flit     = req_flit[int'(g)*FLIT_W +: FLIT_W];
        out_last     = req_last[g];
        out_src      = g;
        req_ready[g] = out_ready;
        if (tail_xfer) begin
          ptr_nxt   = g;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UPLINK_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] pkt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (tail_xfer) begin
      pkt_cnt[g] <= pkt_cnt[g] + CNT_W'(1);
    end
  end

  assign stat_pkts = pkt_cnt;
`endif

endmodule

// File: tb/tb_cluster_uplink_arbiter.sv
// Bench for cluster_uplink_arbiter: per-cycle vector tables, a flit scoreboard, and hand-written corner sequences.
module tb_cluster_uplink_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [79:0] req_flit;
  logic        out_valid, out_last, out_ready, busy;
  logic [19:0] out_flit;
  logic [1:0]  out_src;
`ifdef UPLINK_ARB_STATS_EN
  logic [15:0] stat_pkts;
`endif

  cluster_uplink_arbiter #(
    .NREQ(4), .FLIT_W(20)
`ifdef UPLINK_ARB_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_flit(req_flit), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
`ifdef UPLINK_ARB_STATS_EN
    , .stat_pkts(stat_pkts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  src;
    logic [19:0] flit;
    logic        last;
  } exp_t;

  typedef struct {
    logic       ordy;
    logic       ov;
    logic       bz;
    logic [1:0] src;
    logic [3:0] rdy;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[14];
  logic [19:0] sflit[4][40];
  logic        slast[4][40];
  int          slen[4], spos[4];
  logic        en[4];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      slen[i] = 0;
      spos[i] = 0;
      en[i]   = 1'b1;
    end
    req_valid = '0;
    req_last  = '0;
    req_flit  = '0;
    out_ready = 1'b0;
  endtask

  task automatic load_pkt(input int node, input int nflits, input int tag);
    exp_t        e;
    logic [19:0] f;
    for (int k = 0; k < nflits; k++) begin
      f = {node[3:0], tag[3:0], k[7:0], k[1:0], node[1:0]};
      sflit[node][slen[node]] = f;
      slast[node][slen[node]] = (k == nflits - 1);
      slen[node]++;
      e.src  = node[1:0];
      e.flit = f;
      e.last = (k == nflits - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive_inputs(input logic ordy);
    out_ready = ordy;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && spos[i] < slen[i]) begin
        req_valid[i]         = 1'b1;
        req_flit[i*20 +: 20] = sflit[i][spos[i]];
        req_last[i]          = slast[i][spos[i]];
      end else begin
        req_valid[i]         = 1'b0;
        req_flit[i*20 +: 20] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic sample_xfer();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_flit: got src %0d flit %0h expected none", out_src, out_flit);
      end else begin
        e = sb.pop_front();
        chk("xfer_src", 32'(out_src), 32'(e.src));
        chk("xfer_flit", 32'(out_flit), 32'(e.flit));
        chk("xfer_last", 32'(out_last), 32'(e.last));
      end
    end else if (out_valid && sb.size() > 0) begin
      chk("hold_flit", 32'(out_flit), 32'(sb[0].flit));
    end
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) spos[i]++;
  endtask

  task automatic step(input logic ordy);
    @(negedge clk);
    drive_inputs(ordy);
    #1;
    sample_xfer();
  endtask

  task automatic run_until_empty(input int budget, output int cycles);
    cycles = 0;
    while (sb.size() > 0 && cycles < budget) begin
      step(1'b1);
      cycles++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d flits pending expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_sources();
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vectors(input int first, input int count, input string nm);
    for (int i = first; i < first + count; i++) begin
      step(vt[i].ordy);
      chk({nm, "_valid"}, 32'(out_valid), 32'(vt[i].ov));
      chk({nm, "_busy"}, 32'(busy), 32'(vt[i].bz));
      chk({nm, "_src"}, 32'(out_src), 32'(vt[i].src));
      chk({nm, "_ready"}, 32'(req_ready), 32'(vt[i].rdy));
    end
    chk({nm, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // node 2, 3-flit packet straight out of reset
    vt[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
    // node 1, 4-flit packet with out_ready toggling
    vt[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 2'd1, 4'b0000};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 2'd1, 4'b0000};
    vt[10] = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
    vt[11] = '{1'b0, 1'b1, 1'b1, 2'd1, 4'b0000};
    vt[12] = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
    vt[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};

    clear_sources();
    req_valid = 4'hf;
    req_last  = 4'hf;
    req_flit  = {4{20'hABCDE}};
    out_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_flit", 32'(out_flit), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);

    do_reset();
    load_pkt(2, 3, 1);
    run_vectors(0, 5, "t1");

    load_pkt(1, 4, 2);
    run_vectors(5, 9, "t3");

    // all four nodes, 2-flit packets each: grants 0,1,2,3 in 12 cycles
    do_reset();
    for (int i = 0; i < 4; i++) load_pkt(i, 2, 3);
    run_until_empty(40, n);
    chk("t2_cycles", 32'(n), 32'd12);

    // node 3 stalls mid-packet while node 0 waits
    load_pkt(3, 3, 4);
    load_pkt(0, 1, 4);
    en[0] = 1'b0;
    step(1'b1);
    en[0] = 1'b1;
    step(1'b1);
    en[3] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1);
      chk("t4_valid", 32'(out_valid), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      chk("t4_src", 32'(out_src), 32'd3);
      chk("t4_ready0", 32'(req_ready[0]), 32'd0);
    end
    en[3] = 1'b1;
    run_until_empty(20, n);

    // reset asserted while the second flit is on the uplink
    load_pkt(1, 3, 5);
    step(1'b1);
    step(1'b1);
    @(negedge clk);
    drive_inputs(1'b1);
    #1;
    chk("t5_mid_valid", 32'(out_valid), 32'd1);
    chk("t5_mid_flit", 32'(out_flit), 32'(sb[0].flit));
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_flit", 32'(out_flit), 32'd0);
    chk("t5_rst_last", 32'(out_last), 32'd0);
    chk("t5_rst_src", 32'(out_src), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    clear_sources();
    sb.delete();
    repeat (2) @(negedge clk);
    load_pkt(0, 1, 6);
    load_pkt(3, 1, 6);
    rst = 1'b0;
    run_until_empty(20, n);

`ifdef UPLINK_ARB_STATS_EN
    do_reset();
    for (int p = 0; p < 17; p++) load_pkt(2, 1, p);
    run_until_empty(100, n);
    step(1'b1);
    chk("t6_cnt0", 32'(stat_pkts[3:0]), 32'd0);
    chk("t6_cnt1", 32'(stat_pkts[7:4]), 32'd0);
    chk("t6_cnt2", 32'(stat_pkts[11:8]), 32'd1);
    chk("t6_cnt3", 32'(stat_pkts[15:12]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
